// File: rtl/eth_pkg.sv
// Shared Ethernet TX/RX constants, FSM encoding and FCS byte helper.
package eth_pkg;

  localparam logic [7:0]  ETH_PREAMBLE   = 8'h55;
  localparam logic [7:0]  ETH_SFD        = 8'hD5;
  localparam logic [31:0] CRC_POLY       = 32'hEDB88320;
  localparam logic [31:0] CRC_INIT       = 32'hFFFFFFFF;

  localparam int unsigned ETH_MIN_LEN    = 60;
  localparam int unsigned ETH_MAX_LEN    = 1514;
  localparam int unsigned ETH_IFG_CYCLES = 12;
  localparam int unsigned PRE_CYCLES     = 7;
  localparam int unsigned FCS_BYTES      = 4;
  localparam int unsigned CNT_W          = 11;

  typedef enum logic [2:0] {
    ST_IDLE = 3'd0,
    ST_PRE  = 3'd1,
    ST_SFD  = 3'd2,
    ST_DATA = 3'd3,
    ST_PAD  = 3'd4,
    ST_FCS  = 3'd5,
    ST_IFG  = 3'd6,
    ST_DROP = 3'd7
  } tx_state_t;

  // Wire byte idx (0 = bits [7:0]) of the FCS; a bad FCS skips the final inversion.
  function automatic logic [7:0] fcs_byte(input logic [31:0] crc,
                                          input logic [1:0]  idx,
                                          input logic        bad);
    logic [31:0] v;
    v = bad ? crc : ~crc;
    return 8'(v >> {idx, 3'b000});
  endfunction

endpackage

// File: rtl/crc32_d8.sv
// Byte-wide next-state of the reflected IEEE 802.3 CRC-32; shared by TX and RX FCS logic.
module crc32_d8
  import eth_pkg::*;
(
  input  logic [31:0] crc_in,
  input  logic [7:0]  data,
  output logic [31:0] crc_next_c
);

  logic [31:0] c;

  // LSB-first bit-serial update unrolled over the byte.
  always_comb begin
    c = crc_in;
    for (int i = 0; i < 8; i++) begin
      c = {1'b0, c[31:1]} ^ (((c[0] ^ data[i]) != 1'b0) ? CRC_POLY : 32'h0);
    end
    crc_next_c = c;
  end

endmodule

// File: rtl/eth_mac_tx.sv
// GMII Ethernet transmitter: preamble/SFD framing, zero pad, CRC-32 FCS, IFG,
// with underrun/oversize reported by a deliberately corrupted FCS.
module eth_mac_tx
  import eth_pkg::*;
#(
  parameter int unsigned IFG_CYCLES = ETH_IFG_CYCLES,
  parameter int unsigned MAX_LEN    = ETH_MAX_LEN,
  parameter int unsigned MIN_LEN    = ETH_MIN_LEN
) (
  input  logic       gmii_tx_clk,
  input  logic       rst_n,
  input  logic       s_valid,
  input  logic [7:0] s_data,
  input  logic       s_last,
  output logic       s_ready,
  output logic       gmii_tx_en,
  output logic [7:0] gmii_txd,
  output logic       tx_busy,
  output logic       tx_done,
  output logic       tx_err
);

  tx_state_t         state;
  tx_state_t         state_nxt;

  logic [CNT_W-1:0]  cnt;
  logic [CNT_W-1:0]  cnt_nxt;
  logic [CNT_W-1:0]  cnt_inc;
  logic [31:0]       crc;
  logic [31:0]       crc_nxt;
  logic [31:0]       crc_upd_c;
  logic [7:0]        crc_data_c;
  logic              bad_fcs;
  logic              bad_fcs_nxt;
  logic              drop_after;
  logic              drop_after_nxt;

  logic              en_nxt;
  logic [7:0]        txd_nxt;
  logic              busy_nxt;
  logic              done_nxt;
  logic              err_nxt;

  assign cnt_inc    = cnt + CNT_W'(1);
  assign s_ready    = (state == ST_DATA) || (state == ST_DROP);
  assign crc_data_c = (state == ST_PAD) ? 8'h00 : s_data;

  crc32_d8 u_crc (
    .crc_in     (crc),
    .data       (crc_data_c),
    .crc_next_c (crc_upd_c)
  );

  // State register.
  always_ff @(posedge gmii_tx_clk or negedge rst_n) begin
    if (!rst_n) begin
      state <= ST_IDLE;
    end else begin
      state <= state_nxt;
    end
  end

  // Next-state logic.
  always_comb begin
    state_nxt = state;
    case (state)
      ST_IDLE: if (s_valid) state_nxt = ST_PRE;
      ST_PRE:  if (cnt == CNT_W'(PRE_CYCLES - 1)) state_nxt = ST_SFD;
      ST_SFD:  state_nxt = ST_DATA;
      ST_DATA: begin
        if (!s_valid) begin
          state_nxt = ST_FCS;
        end else if (s_last) begin
          state_nxt = (cnt_inc < CNT_W'(MIN_LEN)) ? ST_PAD : ST_FCS;
        end else if (cnt_inc == CNT_W'(MAX_LEN)) begin
          state_nxt = ST_FCS;
        end
      end
      ST_PAD:  if (cnt_inc == CNT_W'(MIN_LEN)) state_nxt = ST_FCS;
      ST_FCS:  if (cnt == CNT_W'(FCS_BYTES - 1)) state_nxt = drop_after ? ST_DROP : ST_IFG;
      ST_DROP: if (s_valid && s_last) state_nxt = ST_IFG;
      ST_IFG:  if (cnt == CNT_W'(IFG_CYCLES - 1)) state_nxt = ST_IDLE;
      default: state_nxt = ST_IDLE;
    endcase
  end

  // Output and datapath next values; everything below lands on the wire one cycle later.
  always_comb begin
    en_nxt         = 1'b0;
    txd_nxt        = 8'h00;
    busy_nxt       = tx_busy;
    done_nxt       = 1'b0;
    err_nxt        = 1'b0;
    cnt_nxt        = cnt;
    crc_nxt        = crc;
    bad_fcs_nxt    = bad_fcs;
    drop_after_nxt = drop_after;
    case (state)
      ST_IDLE: begin
        crc_nxt        = CRC_INIT;
        cnt_nxt        = '0;
        bad_fcs_nxt    = 1'b0;
        drop_after_nxt = 1'b0;
        busy_nxt       = s_valid;
      end
      ST_PRE: begin
        en_nxt  = 1'b1;
        txd_nxt = ETH_PREAMBLE;
        cnt_nxt = (cnt == CNT_W'(PRE_CYCLES - 1)) ? '0 : cnt_inc;
      end
      ST_SFD: begin
        en_nxt  = 1'b1;
        txd_nxt = ETH_SFD;
        cnt_nxt = '0;
      end
      ST_DATA: begin
        en_nxt = 1'b1;
        if (s_valid) begin
          txd_nxt = s_data;
          crc_nxt = crc_upd_c;
          cnt_nxt = cnt_inc;
          if (s_last) begin
            if (cnt_inc >= CNT_W'(MIN_LEN)) cnt_nxt = '0;
          end else if (cnt_inc == CNT_W'(MAX_LEN)) begin
            cnt_nxt        = '0;
            bad_fcs_nxt    = 1'b1;
            drop_after_nxt = 1'b1;
            err_nxt        = 1'b1;
          end
        end else begin
          // Underrun: first bad FCS byte goes out now so tx_en never gaps.
          txd_nxt        = fcs_byte(crc, 2'd0, 1'b1);
          cnt_nxt        = CNT_W'(1);
          bad_fcs_nxt    = 1'b1;
          drop_after_nxt = 1'b1;
          err_nxt        = 1'b1;
        end
      end
      ST_PAD: begin
        en_nxt  = 1'b1;
        txd_nxt = 8'h00;
        crc_nxt = crc_upd_c;
        cnt_nxt = (cnt_inc == CNT_W'(MIN_LEN)) ? '0 : cnt_inc;
      end
      ST_FCS: begin
        en_nxt  = 1'b1;
        txd_nxt = fcs_byte(crc, cnt[1:0], bad_fcs);
        cnt_nxt = cnt_inc;
        if (cnt == CNT_W'(FCS_BYTES - 1)) begin
          cnt_nxt  = '0;
          done_nxt = 1'b1;
        end
      end
      ST_IFG: begin
        cnt_nxt = cnt_inc;
        if (cnt == CNT_W'(IFG_CYCLES - 1)) begin
          cnt_nxt  = '0;
          busy_nxt = 1'b0;
        end
      end
      default: begin
      end
    endcase
  end

  // Registered outputs and datapath.
  always_ff @(posedge gmii_tx_clk or negedge rst_n) begin
    if (!rst_n) begin
      gmii_tx_en <= 1'b0;
      gmii_txd   <= 8'h00;
      tx_busy    <= 1'b0;
      tx_done    <= 1'b0;
      tx_err     <= 1'b0;
      cnt        <= '0;
      crc        <= CRC_INIT;
      bad_fcs    <= 1'b0;
      drop_after <= 1'b0;
    end else begin
      gmii_tx_en <= en_nxt;
      gmii_txd   <= txd_nxt;
      tx_busy    <= busy_nxt;
      tx_done    <= done_nxt;
      tx_err     <= err_nxt;
      cnt        <= cnt_nxt;
      crc        <= crc_nxt;
      bad_fcs    <= bad_fcs_nxt;
      drop_after <= drop_after_nxt;
    end
  end

endmodule

// File: tb/tb_eth_mac_tx.sv
// Self-checking bench for eth_mac_tx against a queue-based frame model.
module tb_eth_mac_tx;

  typedef logic [7:0] bq_t[$];

  localparam int MIN_LEN = 60;
  localparam int MAX_LEN = 1514;

  logic       gmii_tx_clk = 1'b0;
  logic       rst_n;
  logic       s_valid;
  logic [7:0] s_data;
  logic       s_last;
  logic       s_ready;
  logic       gmii_tx_en;
  logic [7:0] gmii_txd;
  logic       tx_busy;
  logic       tx_done;
  logic       tx_err;

  logic [31:0] u_crc_in;
  logic [7:0]  u_data;
  logic [31:0] u_crc_out;

  int checks   = 0;
  int failures = 0;

  bq_t wire_q;
  int  done_pos_q[$];
  int  gap_q[$];
  int  en_cycles = 0;
  int  err_cnt   = 0;
  int  low_run   = 0;
  bit  seen_fall = 0;
  bit  prev_en   = 0;

  eth_mac_tx dut (
    .gmii_tx_clk (gmii_tx_clk),
    .rst_n       (rst_n),
    .s_valid     (s_valid),
    .s_data      (s_data),
    .s_last      (s_last),
    .s_ready     (s_ready),
    .gmii_tx_en  (gmii_tx_en),
    .gmii_txd    (gmii_txd),
    .tx_busy     (tx_busy),
    .tx_done     (tx_done),
    .tx_err      (tx_err)
  );

  crc32_d8 u_crc (
    .crc_in     (u_crc_in),
    .data       (u_data),
    .crc_next_c (u_crc_out)
  );

  always #4 gmii_tx_clk = ~gmii_tx_clk;

  // Wire monitor, sampled mid-cycle.
  always @(negedge gmii_tx_clk) begin
    if (gmii_tx_en) begin
      if (!prev_en && seen_fall) gap_q.push_back(low_run);
      wire_q.push_back(gmii_txd);
      en_cycles++;
    end else begin
      if (prev_en) begin
        seen_fall = 1;
        low_run   = 0;
      end
      low_run++;
    end
    if (tx_done) done_pos_q.push_back(wire_q.size());
    if (tx_err) err_cnt++;
    prev_en = gmii_tx_en;
  end

  function automatic logic [31:0] sw_crc(input bq_t b);
    logic [31:0] c;
    c = 32'hFFFFFFFF;
    foreach (b[i]) begin
      c = c ^ {24'h0, b[i]};
      repeat (8) c = c[0] ? ((c >> 1) ^ 32'hEDB88320) : (c >> 1);
    end
    return c;
  endfunction

  // Expected wire bytes: preamble, SFD, frame (padded if good), FCS LSB first.
  function automatic bq_t exp_wire(input bq_t frame, input bit bad);
    bq_t body;
    bq_t w;
    logic [31:0] f;
    body = frame;
    if (!bad) while (body.size() < MIN_LEN) body.push_back(8'h00);
    f = bad ? sw_crc(body) : ~sw_crc(body);
    repeat (7) w.push_back(8'h55);
    w.push_back(8'hD5);
    foreach (body[i]) w.push_back(body[i]);
    for (int k = 0; k < 4; k++) w.push_back(f[8*k +: 8]);
    return w;
  endfunction

  function automatic int first_diff(input bq_t a, input bq_t b);
    int n;
    n = (a.size() < b.size()) ? a.size() : b.size();
    for (int i = 0; i < n; i++) if (a[i] !== b[i]) return i;
    if (a.size() != b.size()) return n;
    return -1;
  endfunction

  function automatic bq_t rand_bytes(input int n);
    bq_t q;
    for (int i = 0; i < n; i++) q.push_back(8'($urandom));
    return q;
  endfunction

  task automatic clr_mon();
    wire_q.delete();
    done_pos_q.delete();
    gap_q.delete();
    en_cycles = 0;
    err_cnt   = 0;
    low_run   = 0;
    seen_fall = 0;
  endtask

  // Offer bytes one per handshake; returns the number accepted (bounded wait).
  task automatic drive(input bq_t b, input bit with_last, output int acc);
    int   budget;
    logic rdy;
    acc    = 0;
    budget = 0;
    while (acc < b.size() && budget < 200) begin
      s_valid = 1'b1;
      s_data  = b[acc];
      s_last  = with_last && (acc == b.size() - 1);
      @(negedge gmii_tx_clk);
      rdy = s_ready;
      @(posedge gmii_tx_clk);
      #1;
      if (rdy) begin
        acc++;
        budget = 0;
      end else begin
        budget++;
      end
    end
    s_valid = 1'b0;
    s_last  = 1'b0;
    s_data  = 8'h00;
  endtask

  task automatic wait_idle(output bit ok);
    ok = 0;
    for (int i = 0; i < 3000; i++) begin
      @(negedge gmii_tx_clk);
      if (!tx_busy) begin
        ok = 1;
        break;
      end
    end
    @(posedge gmii_tx_clk);
    #1;
  endtask

  task automatic test_reset();
    rst_n   = 1'b0;
    s_valid = 1'b0;
    s_data  = 8'h00;
    s_last  = 1'b0;
    #18;
    checks++; if (gmii_tx_en !== 1'b0) begin failures++; $display("FAIL rst_en: got %b expected 0", gmii_tx_en); end
    checks++; if (gmii_txd !== 8'h00) begin failures++; $display("FAIL rst_txd: got %h expected 00", gmii_txd); end
    checks++; if (s_ready !== 1'b0) begin failures++; $display("FAIL rst_ready: got %b expected 0", s_ready); end
    checks++; if (tx_busy !== 1'b0) begin failures++; $display("FAIL rst_busy: got %b expected 0", tx_busy); end
    checks++; if (tx_done !== 1'b0) begin failures++; $display("FAIL rst_done: got %b expected 0", tx_done); end
    checks++; if (tx_err !== 1'b0) begin failures++; $display("FAIL rst_err: got %b expected 0", tx_err); end
    @(negedge gmii_tx_clk);
    rst_n = 1'b1;
  endtask

  task automatic test_crc_unit();
    logic [31:0] c;
    c = 32'hFFFFFFFF;
    for (int i = 0; i < 9; i++) begin
      u_crc_in = c;
      u_data   = 8'(8'h31 + i);
      #1;
      c = u_crc_out;
    end
    checks++;
    if (~c !== 32'hCBF43926) begin failures++; $display("FAIL crc_check: got %h expected cbf43926", ~c); end
  endtask

  task automatic test_frame64();
    bq_t f, e;
    int  acc, d;
    bit  ok;
    for (int i = 0; i < 60; i++) f.push_back(8'(i));
    e = exp_wire(f, 0);
    @(posedge gmii_tx_clk); #1; clr_mon();
    drive(f, 1, acc);
    wait_idle(ok);
    checks++; if (acc != 60 || !ok) begin failures++; $display("FAIL f64_accept: got %0d idle=%0b expected 60 idle=1", acc, ok); end
    d = first_diff(wire_q, e);
    checks++; if (d != -1) begin failures++; $display("FAIL f64_wire: diff at %0d got %0d bytes expected %0d", d, wire_q.size(), e.size()); end
    checks++; if (en_cycles != 72) begin failures++; $display("FAIL f64_en: got %0d expected 72", en_cycles); end
    checks++; if (done_pos_q.size() != 1 || done_pos_q[0] != 72) begin failures++; $display("FAIL f64_done: got %0d pulses expected 1 at 72", done_pos_q.size()); end
    checks++; if (err_cnt != 0) begin failures++; $display("FAIL f64_err: got %0d expected 0", err_cnt); end
  endtask

  task automatic test_pad();
    bq_t f, e;
    int  acc, d;
    bit  ok;
    f = rand_bytes(14);
    e = exp_wire(f, 0);
    @(posedge gmii_tx_clk); #1; clr_mon();
    drive(f, 1, acc);
    wait_idle(ok);
    d = first_diff(wire_q, e);
    checks++; if (d != -1 || !ok) begin failures++; $display("FAIL pad_wire: diff at %0d got %0d bytes expected %0d", d, wire_q.size(), e.size()); end
    checks++; if (en_cycles != 72) begin failures++; $display("FAIL pad_en: got %0d expected 72", en_cycles); end
    checks++; if (done_pos_q.size() != 1 || err_cnt != 0) begin failures++; $display("FAIL pad_flags: got done=%0d err=%0d expected 1/0", done_pos_q.size(), err_cnt); end
  endtask

  task automatic test_random_frames();
    bq_t f, e;
    int  acc, d, n, exp_en;
    bit  ok;
    for (int k = 0; k < 7; k++) begin
      n = (k == 6) ? MAX_LEN : int'($urandom_range(1, 120));
      f = rand_bytes(n);
      e = exp_wire(f, 0);
      exp_en = ((n < MIN_LEN) ? MIN_LEN : n) + 12;
      @(posedge gmii_tx_clk); #1; clr_mon();
      drive(f, 1, acc);
      wait_idle(ok);
      d = first_diff(wire_q, e);
      checks++; if (d != -1 || acc != n || !ok) begin failures++; $display("FAIL rnd_wire len=%0d: diff at %0d got %0d bytes expected %0d", n, d, wire_q.size(), e.size()); end
      checks++; if (en_cycles != exp_en || err_cnt != 0 || done_pos_q.size() != 1) begin failures++; $display("FAIL rnd_flags len=%0d: got en=%0d err=%0d done=%0d expected %0d/0/1", n, en_cycles, err_cnt, done_pos_q.size(), exp_en); end
    end
  endtask

  task automatic test_underrun();
    bq_t f, head, tail, e;
    int  acc1, acc2, d;
    bit  ok;
    f = rand_bytes(100);
    head = f[0:19];
    tail = f[20:99];
    e = exp_wire(head, 1);
    @(posedge gmii_tx_clk); #1; clr_mon();
    drive(head, 0, acc1);
    repeat (2) @(posedge gmii_tx_clk);
    #1;
    drive(tail, 1, acc2);
    wait_idle(ok);
    d = first_diff(wire_q, e);
    checks++; if (d != -1) begin failures++; $display("FAIL ur_wire: diff at %0d got %0d bytes expected %0d", d, wire_q.size(), e.size()); end
    checks++; if (err_cnt != 1) begin failures++; $display("FAIL ur_err: got %0d expected 1", err_cnt); end
    checks++; if (done_pos_q.size() != 1 || done_pos_q[0] != 32) begin failures++; $display("FAIL ur_done: got %0d pulses expected 1 at 32", done_pos_q.size()); end
    checks++; if (acc1 + acc2 != 100 || !ok) begin failures++; $display("FAIL ur_drop: got %0d accepted expected 100", acc1 + acc2); end
  endtask

  task automatic test_oversize();
    bq_t f, e;
    int  acc, d;
    bit  ok;
    f = rand_bytes(1600);
    e = exp_wire(f[0:MAX_LEN-1], 1);
    @(posedge gmii_tx_clk); #1; clr_mon();
    drive(f, 1, acc);
    wait_idle(ok);
    d = first_diff(wire_q, e);
    checks++; if (d != -1) begin failures++; $display("FAIL ovs_wire: diff at %0d got %0d bytes expected %0d", d, wire_q.size(), e.size()); end
    checks++; if (err_cnt != 1 || done_pos_q.size() != 1) begin failures++; $display("FAIL ovs_flags: got err=%0d done=%0d expected 1/1", err_cnt, done_pos_q.size()); end
    checks++; if (acc != 1600 || !ok) begin failures++; $display("FAIL ovs_drop: got %0d accepted expected 1600", acc); end
  endtask

  task automatic test_back_to_back();
    bq_t f1, f2, e;
    int  acc1, acc2, d;
    bit  ok;
    f1 = rand_bytes(60);
    f2 = rand_bytes(60);
    e = exp_wire(f1, 0);
    e = {e, exp_wire(f2, 0)};
    @(posedge gmii_tx_clk); #1; clr_mon();
    drive(f1, 1, acc1);
    drive(f2, 1, acc2);
    wait_idle(ok);
    d = first_diff(wire_q, e);
    checks++; if (d != -1 || acc1 + acc2 != 120) begin failures++; $display("FAIL b2b_wire: diff at %0d got %0d bytes expected %0d", d, wire_q.size(), e.size()); end
    checks++; if (gap_q.size() != 1 || gap_q[0] != 13) begin failures++; $display("FAIL b2b_gap: got %0d gaps first=%0d expected 1 of 13", gap_q.size(), (gap_q.size() > 0) ? gap_q[0] : -1); end
    checks++; if (done_pos_q.size() != 2 || done_pos_q[1] != 144) begin failures++; $display("FAIL b2b_done: got %0d pulses expected 2", done_pos_q.size()); end
  endtask

  task automatic test_reset_mid();
    bq_t f, e;
    int  acc, d;
    bit  ok;
    f = rand_bytes(10);
    @(posedge gmii_tx_clk); #1; clr_mon();
    drive(f, 0, acc);
    checks++; if (gmii_tx_en !== 1'b1 || acc != 10) begin failures++; $display("FAIL rm_pre: got en=%b acc=%0d expected 1/10", gmii_tx_en, acc); end
    #1 rst_n = 1'b0;
    #1;
    checks++; if (gmii_tx_en !== 1'b0 || gmii_txd !== 8'h00) begin failures++; $display("FAIL rm_async: got en=%b txd=%h expected 0/00", gmii_tx_en, gmii_txd); end
    checks++; if (tx_busy !== 1'b0 || s_ready !== 1'b0 || tx_err !== 1'b0 || tx_done !== 1'b0) begin failures++; $display("FAIL rm_outs: got busy=%b rdy=%b err=%b done=%b expected 0", tx_busy, s_ready, tx_err, tx_done); end
    @(negedge gmii_tx_clk);
    rst_n = 1'b1;
    f = rand_bytes(60);
    e = exp_wire(f, 0);
    @(posedge gmii_tx_clk); #1; clr_mon();
    drive(f, 1, acc);
    wait_idle(ok);
    d = first_diff(wire_q, e);
    checks++; if (d != -1 || !ok) begin failures++; $display("FAIL rm_next: diff at %0d got %0d bytes expected %0d", d, wire_q.size(), e.size()); end
    checks++; if (err_cnt != 0 || done_pos_q.size() != 1) begin failures++; $display("FAIL rm_flags: got err=%0d done=%0d expected 0/1", err_cnt, done_pos_q.size()); end
  endtask

  initial begin
    test_reset();
    test_crc_unit();
    test_frame64();
    test_pad();
    test_random_frames();
    test_underrun();
    test_oversize();
    test_back_to_back();
    test_reset_mid();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1, "watchdog");
  end

endmodule

// File: doc/eth_mac_tx.md
Name: eth_mac_tx

Overview:
- GMII-side Ethernet frame transmitter. It drives the gmii_tx_en/gmii_txd inputs of the RGMII/GMII converter.
- Takes an upstream byte stream (destination MAC through end of payload) over a valid/ready handshake.
- Emits preamble, SFD, the frame, zero padding to the 60-byte minimum, FCS (CRC-32) and inter-frame gap.
- Runs entirely in gmii_tx_clk (125 MHz, 1000BASE-T).

Parameters:
- IFG_CYCLES, 12, idle cycles after the last FCS byte before the next frame may start (min 12).
- MAX_LEN, 1514, maximum bytes accepted per frame, excluding FCS.
- MIN_LEN, 60, minimum frame bytes before FCS; shorter frames are zero-padded.

Ports:
- gmii_tx_clk  input  1  GMII transmit clock; the only clock.
- rst_n  input  1  asynchronous active-low reset.
- s_valid  input  1  upstream byte valid.
- s_data  input  8  upstream byte.
- s_last  input  1  marks the final frame byte.
- s_ready  output  1  byte accepted when s_valid&s_ready.
- gmii_tx_en  output  1  GMII transmit enable.
- gmii_txd  output  8  GMII transmit data.
- tx_busy  output  1  high from frame start through end of IFG.
- tx_done  output  1  one-cycle pulse with the last FCS byte on the wire.
- tx_err  output  1  one-cycle pulse on underrun or oversize.

Behaviour:
- Interface: one clock (gmii_tx_clk); reset is asynchronous, active-low (rst_n).
- Reset values: gmii_tx_en=0, gmii_txd=8'h00, s_ready=0, tx_busy=0, tx_done=0, tx_err=0. FSM goes to IDLE, counters are cleared, CRC is set to 32'hFFFFFFFF.
- Reset mid-frame: gmii_tx_en drops immediately (async). No FCS is sent and no tx_err is raised.
- Registered outputs: gmii_tx_en and gmii_txd are registered. s_ready is combinational: (state==DATA)||(state==DROP).
- FSM states: IDLE, PRE, SFD, DATA, PAD, FCS, IFG, DROP.
- IDLE: when s_valid=1 (s_data not consumed), go to PRE and set tx_busy=1. The first 0x55 appears on the wire the next cycle.
- PRE: 7 cycles, each registering 0x55, then SFD.
- SFD: registers 0xD5, then DATA.
- DATA:
  - Each accepted byte appears on gmii_txd exactly one cycle after the handshake. Wire bytes are contiguous with gmii_tx_en=1 throughout.
  - Each accepted byte is fed to the CRC, and the 11-bit byte counter increments.
- s_last accepted in DATA:
  - If count (including this byte) < MIN_LEN, go to PAD.
  - Otherwise go to FCS.
- PAD: emits 0x00 (CRC-updated) until count == MIN_LEN, then FCS.
- FCS:
  - 4 cycles emitting ~crc, LSB byte first (bits [7:0] first).
  - tx_done pulses in the cycle the 4th byte is on the wire.
- Underrun: s_valid=0 in DATA before s_last.
  - Go to FCS and emit the uncomplemented crc (a deliberately bad FCS).
  - Pulse tx_err. tx_done still pulses.
  - The remaining upstream bytes of that frame are discarded via DROP.
- Oversize: count reaches MAX_LEN without s_last.
  - Go to FCS with a bad FCS and pulse tx_err.
  - After FCS, enter DROP.
- DROP: s_ready=1 and bytes are discarded until s_last is accepted, then IFG. gmii_tx_en=0 throughout.
- Simultaneous s_last with count==MAX_LEN: this is a normal frame, not an error.
- IFG: gmii_tx_en=0, gmii_txd=0x00 for IFG_CYCLES cycles, then IDLE with tx_busy=0. s_valid is ignored during IFG.
- Back-to-back frames: a frame held valid during IFG starts PRE the cycle after IFG ends (1 IDLE cycle).
- CRC: IEEE 802.3 reflected polynomial 0xEDB88320, init 32'hFFFFFFFF. It covers frame and pad bytes only (not preamble/SFD), and is reset in IDLE.

Decomposition:
- Package eth_pkg holds: ETH_PREAMBLE=8'h55, ETH_SFD=8'hD5, CRC_POLY=32'hEDB88320, CRC_INIT=32'hFFFFFFFF, the state enum encoding, and the MIN_LEN/MAX_LEN defaults.
- Sub-module crc32_d8: purely combinational next-CRC of (crc_in[31:0], data[7:0]). It is reused by the future receive-side FCS checker.

Test Plan:
- 64-byte frame (60 bytes 0x00..0x3B, s_last on byte 60), valid held high:
  - wire shows 7×0x55, 0xD5, 60 bytes, 4 FCS bytes matching the software CRC model;
  - gmii_tx_en high for exactly 72 cycles; tx_done on the final cycle.
- 14-byte frame: 46 bytes of 0x00 pad after the data, then correct FCS over 60 bytes. Total en-high cycles = 72.
- crc32_d8 unit: feed ASCII "123456789" from init → ~crc = 32'hCBF43926, wire order 26 39 F4 CB.
- Underrun: drop s_valid after byte 20 of a 100-byte frame → 4 FCS bytes equal to the uncomplemented CRC, one tx_err pulse, remaining 80 bytes swallowed with gmii_tx_en=0.
- Oversize: 1600 bytes with no s_last before 1600:
  - byte 1514 is the last on the wire, then bad FCS and tx_err;
  - the remaining 86 bytes are dropped.
- Back-to-back plus reset:
  - two 60-byte frames → exactly 12 en-low cycles (+1 IDLE) between them;
  - assert rst_n=0 mid-DATA of a third frame → gmii_tx_en=0 asynchronously, outputs at reset values, next frame transmits cleanly.
